dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//  Sits directly downstream of the LSU (mem stage). Turns the LSU's single-cycle combinational
//  RAM request (ce/we/addr/sel/data) into a registered req/ack bus transaction with wait states.
//  Stalls the pipeline until the access completes, then returns read data and an access-fault flag.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY/DRAIN cycles without ack before forced fault (used only with DMEM_TIMEOUT_EN)
// PORTS
//  clk_i         in   1   core clock
//  n_rst_i       in   1   reset, asynchronous, active-low
//  mem_ce_i      in   1   LSU access request (load or store)
//  mem_we_i      in   1   1=store, 0=load
//  mem_addr_i    in   32  byte address
//  mem_sel_i     in   4   byte-lane enables, forwarded unchanged
//  mem_data_i    in   32  store data
//  flush_i       in   1   ctrl flush of the mem-stage instruction
//  mem_data_o    out  32  load data to LSU (registered)
//  fault_o       out  1   access fault for current access, valid in DONE only
//  stall_req_o   out  1   stall request to ctrl (combinational)
//  bus_req_o     out  1   bus request, held until ack
//  bus_we_o      out  1   bus write enable
//  bus_addr_o    out  32  bus address
//  bus_sel_o     out  4   bus byte lanes
//  bus_wdata_o   out  32  bus write data
//  bus_ack_i     in   1   transaction complete, single-cycle pulse
//  bus_err_i     in   1   transaction error, qualified by bus_ack_i
//  bus_rdata_i   in   32  read data, valid with bus_ack_i
// BEHAVIOUR
//  - Reset: state=IDLE; all bus_* outputs, mem_data_o and fault_o = 0; stall_req_o forced 0 while n_rst_i low.
//    Reset mid-transaction drops bus_req_o immediately, with no completion.
//  - FSM states: IDLE, BUSY, DONE, DRAIN.
//  - IDLE:
//    - mem_ce_i=1 and flush_i=0: latch we/addr/sel/wdata into bus_* and set bus_req_o; go to BUSY.
//    - mem_ce_i=1 and flush_i=1: no request; stay in IDLE.
//  - BUSY: bus_req_o=1 and bus_* held stable.
//    - bus_ack_i: bus_req_o<=0; mem_data_o<=(err|we)?0:bus_rdata_i; fault_o<=bus_err_i; go to DONE.
//    - flush_i with no ack: go to DRAIN; the transaction is not abandoned.
//    - flush_i with ack in the same cycle: go to IDLE; result is discarded and mem_data_o is unchanged.
//  - DONE: lasts exactly 1 cycle with stall_req_o=0, so the pipeline advances on this edge.
//    Next state is always IDLE. fault_o is cleared on exit.
//  - DRAIN: bus_req_o stays 1 until bus_ack_i. The result is discarded and fault_o is not raised.
//    Then go to IDLE.
//  - stall_req_o = (IDLE & mem_ce_i & ~flush_i) | BUSY | (DRAIN & mem_ce_i).
//  - Latency: ack in the first BUSY cycle gives 2 stall cycles (IDLE, BUSY), then DONE.
//    Each ack wait cycle adds 1.
//  - Back-to-back accesses: DONE->IDLE always, so the minimum is 3 cycles per access and there is no overlap.
//  - bus_ack_i outside BUSY/DRAIN is ignored. bus_err_i without ack is ignored.
//  - mem_data_o holds its last value between accesses. Store completion writes 0 to it.
// CONFIGURATION
//  - DMEM_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYCLES+1) resets on entry to BUSY/DRAIN
//    and increments each BUSY/DRAIN cycle without ack.
//    - At TIMEOUT_CYCLES in BUSY: behave as ack with err (bus_req_o<=0, fault_o=1 in DONE).
//    - At TIMEOUT_CYCLES in DRAIN: go to IDLE silently.
//    - A late ack after timeout is ignored.
//  - DMEM_TIMEOUT_EN undefined: no counter; wait for ack indefinitely; fault only from bus_err_i.
// TESTING
//  - LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> bus_req_o high 4 cycles, stall_req_o high
//    5 cycles, mem_data_o=0xDEADBEEF and fault_o=0 in DONE.
//  - SB addr 0x203 sel 4'b1000 data 0x000000AB, ack at once -> bus_we_o=1, bus_sel_o=4'b1000,
//    bus_wdata_o=0x000000AB, 2 stall cycles, mem_data_o=0.
//  - LW with bus_err_i=1 on ack -> fault_o=1 for 1 DONE cycle, mem_data_o=0, then IDLE.
//  - flush_i in 2nd BUSY cycle, ack 4 cycles later -> bus_req_o held until ack, no fault;
//    a new mem_ce_i during DRAIN is stalled, then issued from IDLE.
//  - n_rst_i low in BUSY -> bus_req_o=0 and stall_req_o=0 immediately; a late ack after reset is ignored.
//  - DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req_o drops after 4 BUSY cycles, fault_o=1 in DONE.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the LSU's single-cycle RAM request into a registered req/ack bus access and stalls the pipeline until it completes.
// Optional DMEM_TIMEOUT_EN adds the TIMEOUT_CYCLES watchdog. Without it the bridge waits for ack indefinitely.

module dmem_bridge
`ifdef DMEM_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
   input  logic        clk_i,
   input  logic        n_rst_i,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   input  logic        flush_i,
   output logic [31:0] mem_data_o,
   output logic        fault_o,
   output logic        stall_req_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   input  logic [31:0] bus_rdata_i
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

   state_t      state_reg, state_next;
   logic        req_reg, req_next;
   logic        we_reg, we_next;
   logic [31:0] addr_reg, addr_next;
   logic [3:0]  sel_reg, sel_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [31:0] rdata_reg, rdata_next;
   logic        fault_reg, fault_next;
   logic        stall;
   logic        done_evt;
   logic        err_evt;

`ifdef DMEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] cnt_reg;
   logic          timeout;

   // The final waiting cycle acts as an ack carrying an error.
   assign timeout  = ((state_reg == BUSY) || (state_reg == DRAIN)) && !bus_ack_i && (cnt_reg == CNT_LAST);
   assign done_evt = bus_ack_i | timeout;
   assign err_evt  = bus_err_i | timeout;

   // Staying in BUSY/DRAIN means no ack this cycle; any entry or exit restarts the count.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         cnt_reg <= '0;
      end else if (((state_reg == BUSY) || (state_reg == DRAIN)) && (state_next == state_reg)) begin
         cnt_reg <= cnt_reg + TW'(1);
      end else begin
         cnt_reg <= '0;
      end
   end
`else
   assign done_evt = bus_ack_i;
   assign err_evt  = bus_err_i;
`endif

   always_comb begin
      state_next = state_reg;
      req_next   = req_reg;
      we_next    = we_reg;
      addr_next  = addr_reg;
      sel_next   = sel_reg;
      wdata_next = wdata_reg;
      rdata_next = rdata_reg;
      fault_next = 1'b0;
      stall      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (mem_ce_i && !flush_i) begin
               stall      = 1'b1;
               req_next   = 1'b1;
               we_next    = mem_we_i;
               addr_next  = mem_addr_i;
               sel_next   = mem_sel_i;
               wdata_next = mem_data_i;
               state_next = BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (done_evt) begin
               req_next = 1'b0;
               if (flush_i) begin
                  state_next = IDLE;
               end else begin
                  fault_next = err_evt;
                  rdata_next = (err_evt || we_reg) ? 32'd0 : bus_rdata_i;
                  state_next = DONE;
               end
            end else if (flush_i) begin
               state_next = DRAIN;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         DRAIN: begin
            // The next instruction may already be presenting a request; hold it off.
            stall = mem_ce_i;
            if (done_evt) begin
               req_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state_reg <= IDLE;
         req_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= 32'd0;
         sel_reg   <= 4'd0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
         fault_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         req_reg   <= req_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         sel_reg   <= sel_next;
         wdata_reg <= wdata_next;
         rdata_reg <= rdata_next;
         fault_reg <= fault_next;
      end
   end

   assign stall_req_o = n_rst_i & stall;
   assign bus_req_o   = req_reg;
   assign bus_we_o    = we_reg;
   assign bus_addr_o  = addr_reg;
   assign bus_sel_o   = sel_reg;
   assign bus_wdata_o = wdata_reg;
   assign mem_data_o  = rdata_reg;
   assign fault_o     = fault_reg;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: transaction-level model checked every cycle, plus directed accesses with literal expectations.

module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        mem_ce, mem_we, flush;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_sel;
   logic [31:0] mem_data_o;
   logic        fault_o, stall_o;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_sel;
   logic        bus_ack, bus_err;
   logic [31:0] bus_rdata;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

`ifdef DMEM_TIMEOUT_EN
   localparam int TO = 4;
   dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
`else
   dmem_bridge dut (
`endif
      .clk_i(clk), .n_rst_i(n_rst),
      .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
      .mem_sel_i(mem_sel), .mem_data_i(mem_wdata), .flush_i(flush),
      .mem_data_o(mem_data_o), .fault_o(fault_o), .stall_req_o(stall_o),
      .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
      .bus_sel_o(bus_sel), .bus_wdata_o(bus_wdata),
      .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else passes++;
   endtask

   // Model: an access is either absent, outstanding (result wanted), outstanding but discarded, or just completed.
   logic        m_out, m_drop, m_done, m_req, m_we, m_fault;
   logic [31:0] m_addr, m_wdata, m_data;
   logic [3:0]  m_sel;
   int          m_wait;
   logic        m_to, m_ev, m_er, m_stall;

`ifdef DMEM_TIMEOUT_EN
   assign m_to = m_out && !bus_ack && (m_wait == TO - 1);
`else
   assign m_to = 1'b0;
`endif
   assign m_ev = bus_ack | m_to;
   assign m_er = bus_err | m_to;
   assign m_stall = n_rst && ((!m_out && !m_done && mem_ce && !flush) ||
                              (m_out && !m_drop) || (m_drop && mem_ce));

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_out <= 0; m_drop <= 0; m_done <= 0; m_req <= 0; m_we <= 0; m_fault <= 0;
         m_addr <= 0; m_wdata <= 0; m_data <= 0; m_sel <= 0; m_wait <= 0;
      end else begin
         m_fault <= 1'b0;
         if (m_done) begin
            m_done <= 1'b0;
         end else if (m_out && !m_drop) begin
            if (m_ev) begin
               m_req <= 1'b0;
               m_out <= 1'b0;
               if (!flush) begin
                  m_done  <= 1'b1;
                  m_fault <= m_er;
                  m_data  <= (m_er || m_we) ? 32'd0 : bus_rdata;
               end
            end else if (flush) begin
               m_drop <= 1'b1;
               m_wait <= 0;
            end else begin
               m_wait <= m_wait + 1;
            end
         end else if (m_out) begin
            if (m_ev) begin
               m_req <= 1'b0; m_out <= 1'b0; m_drop <= 1'b0;
            end else begin
               m_wait <= m_wait + 1;
            end
         end else if (mem_ce && !flush) begin
            m_out <= 1'b1; m_req <= 1'b1; m_wait <= 0;
            m_we <= mem_we; m_addr <= mem_addr; m_sel <= mem_sel; m_wdata <= mem_wdata;
         end
      end
   end

   always @(negedge clk) begin
      chk("stall_req", 32'(stall_o), 32'(m_stall));
      chk("bus_req", 32'(bus_req), 32'(m_req));
      chk("bus_we", 32'(bus_we), 32'(m_we));
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_sel", 32'(bus_sel), 32'(m_sel));
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("mem_data", mem_data_o, m_data);
      chk("fault", 32'(fault_o), 32'(m_fault));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_ce = 0; mem_we = 0; flush = 0; bus_ack = 0; bus_err = 0; bus_rdata = 0;
   endtask

   // Cycle 0 issues from IDLE, cycles 1..waitc+1 are BUSY (ack in the last), cycle waitc+2 is DONE.
   task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input int waitc, input logic err,
                         input logic [31:0] rdata, output int stalls, output int reqs,
                         output logic [31:0] d_done, output logic f_done,
                         output logic [31:0] a_s, output logic w_s, output logic [3:0] s_s,
                         output logic [31:0] wd_s);
      stalls = 0; reqs = 0;
      d_done = 'x; f_done = 'x; a_s = 'x; w_s = 'x; s_s = 'x; wd_s = 'x;
      for (int c = 0; c <= waitc + 2; c++) begin
         mem_ce = 1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wdata; flush = 0;
         bus_ack   = (c == waitc + 1);
         bus_err   = err && (c >= 1) && (c <= waitc + 1);
         bus_rdata = (c == waitc + 1) ? rdata : 32'hBADC0DE0 + 32'(c);
         @(negedge clk);
         stalls += int'(stall_o);
         reqs   += int'(bus_req);
         if (c == 1) begin a_s = bus_addr; w_s = bus_we; s_s = bus_sel; wd_s = bus_wdata; end
         if (c == waitc + 2) begin d_done = mem_data_o; f_done = fault_o; end
         step();
      end
      idle_inputs();
   endtask

   int          st, rq;
   logic [31:0] dd, aa, wd;
   logic        ff, ww;
   logic [3:0]  ss;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      mem_addr = 0; mem_sel = 0; mem_wdata = 0;
      n_rst = 0;
      mem_ce = 1;
      @(negedge clk);
      chk("reset_stall", 32'(stall_o), 32'd0);
      chk("reset_req", 32'(bus_req), 32'd0);
      chk("reset_data", mem_data_o, 32'd0);
      mem_ce = 0;
      step();
      n_rst = 1;
      step();

      // LW 0x100, three wait cycles
      access(1'b0, 32'h100, 4'hF, 32'h0, 3, 1'b0, 32'hDEADBEEF, st, rq, dd, ff, aa, ww, ss, wd);
      $display("LW  addr=%h stalls=%0d reqs=%0d data=%h fault=%0d", aa, st, rq, dd, ff);
      chk("lw_stalls", 32'(st), 32'd5);
      chk("lw_reqs", 32'(rq), 32'd4);
      chk("lw_data", dd, 32'hDEADBEEF);
      chk("lw_fault", 32'(ff), 32'd0);
      chk("lw_addr", aa, 32'h100);

      // LW with error on ack
      access(1'b0, 32'h104, 4'hF, 32'h0, 1, 1'b1, 32'h12345678, st, rq, dd, ff, aa, ww, ss, wd);
      $display("LWE addr=%h stalls=%0d data=%h fault=%0d", aa, st, dd, ff);
      chk("err_stalls", 32'(st), 32'd3);
      chk("err_data", dd, 32'd0);
      chk("err_fault", 32'(ff), 32'd1);
      @(negedge clk);
      chk("err_fault_clear", 32'(fault_o), 32'd0);
      step();

      // SB 0x203, immediate ack
      access(1'b1, 32'h203, 4'b1000, 32'h000000AB, 0, 1'b0, 32'hFFFFFFFF, st, rq, dd, ff, aa, ww, ss, wd);
      $display("SB  addr=%h we=%0d sel=%b wdata=%h stalls=%0d data=%h", aa, ww, ss, wd, st, dd);
      chk("sb_we", 32'(ww), 32'd1);
      chk("sb_sel", 32'(ss), 32'b1000);
      chk("sb_wdata", wd, 32'h000000AB);
      chk("sb_stalls", 32'(st), 32'd2);
      chk("sb_data", dd, 32'd0);

      access(1'b0, 32'h108, 4'hF, 32'h0, 2, 1'b0, 32'hCAFEF00D, st, rq, dd, ff, aa, ww, ss, wd);
      $display("LW  addr=%h data=%h", aa, dd);
      chk("lw2_data", dd, 32'hCAFEF00D);
      repeat (2) step();

      // Flush in 2nd BUSY cycle, ack 4 cycles later; next load waits through DRAIN
      st = 0; rq = 0; ff = 0;
      for (int c = 0; c <= 9; c++) begin
         mem_ce = 1; mem_we = 0; mem_sel = 4'hF; flush = (c == 2);
         mem_addr  = (c <= 2) ? 32'h180 : 32'h300;
         bus_ack   = (c == 6) || (c == 8);
         bus_rdata = (c == 6) ? 32'h11111111 : ((c == 8) ? 32'h55AA55AA : 32'h0);
         @(negedge clk);
         st += int'(stall_o);
         rq += int'(bus_req);
         if (c <= 8) ff = ff | fault_o;
         if (c == 7) chk("drain_discard", mem_data_o, 32'hCAFEF00D);
         if (c == 8) chk("drain_next_addr", bus_addr, 32'h300);
         if (c == 9) chk("drain_next_data", mem_data_o, 32'h55AA55AA);
         step();
      end
      idle_inputs();
      $display("FLUSH stalls=%0d reqs=%0d fault_seen=%0d data=%h", st, rq, ff, mem_data_o);
      chk("drain_stalls", 32'(st), 32'd9);
      chk("drain_reqs", 32'(rq), 32'd7);
      chk("drain_fault", 32'(ff), 32'd0);

      // Flush together with ack: result dropped
      mem_ce = 1; mem_addr = 32'h190;
      step();
      bus_ack = 1; flush = 1; bus_rdata = 32'h99999999;
      step();
      idle_inputs();
      @(negedge clk);
      $display("ACK+FLUSH data=%h req=%0d stall=%0d", mem_data_o, bus_req, stall_o);
      chk("ackflush_data", mem_data_o, 32'h55AA55AA);
      chk("ackflush_req", 32'(bus_req), 32'd0);
      step();

      // Request flushed in IDLE never reaches the bus
      mem_ce = 1; flush = 1; mem_addr = 32'h400;
      @(negedge clk);
      chk("idleflush_stall", 32'(stall_o), 32'd0);
      step();
      idle_inputs();
      @(negedge clk);
      $display("IDLE-FLUSH req=%0d", bus_req);
      chk("idleflush_req", 32'(bus_req), 32'd0);
      step();

      // Reset in BUSY, then a late ack
      mem_ce = 1; mem_addr = 32'h500;
      step();
      #1 n_rst = 0;
      #1;
      chk("rst_busy_req", 32'(bus_req), 32'd0);
      chk("rst_busy_stall", 32'(stall_o), 32'd0);
      step();
      n_rst = 1; mem_ce = 0; bus_ack = 1; bus_rdata = 32'h77777777;
      @(negedge clk);
      chk("late_ack_req", 32'(bus_req), 32'd0);
      step();
      bus_ack = 0;
      @(negedge clk);
      $display("RESET-IN-BUSY req=%0d data=%h fault=%0d", bus_req, mem_data_o, fault_o);
      chk("late_ack_data", mem_data_o, 32'd0);
      chk("late_ack_fault", 32'(fault_o), 32'd0);
      step();

`ifdef DMEM_TIMEOUT_EN
      // No ack at all: watchdog ends the access with a fault
      rq = 0; ff = 0;
      for (int c = 0; c <= 6; c++) begin
         mem_ce = (c <= 5); mem_addr = 32'h600;
         bus_ack = (c == 6);
         @(negedge clk);
         rq += int'(bus_req);
         if (c == 5) ff = fault_o;
         step();
      end
      idle_inputs();
      $display("TIMEOUT reqs=%0d fault=%0d", rq, ff);
      chk("to_reqs", 32'(rq), 32'd4);
      chk("to_fault", 32'(ff), 32'd1);
`endif

      repeat (3) step();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
